// File: rtl/bgm_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : bgm_player_if
//  Purpose  : Tone-table bus between bgm_player and the external tone ROM.
//             The player drives the beat index; the ROM returns the frequency
//             (Hz) for that index combinationally in the same cycle.
//  Signals  : beat_num  current table index (player -> ROM)
//             tone      frequency in Hz for beat_num (ROM -> player)
//  Modports : master = player side, slave = tone ROM side
//  Revision : 1.0  initial release
// ============================================================================
interface bgm_player_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0] beat_num;
    logic [31:0]       tone;

    modport master (output beat_num, input  tone);
    modport slave  (input  beat_num, output tone);
endinterface
`default_nettype wire

// File: rtl/bgm_player.sv
`default_nettype none
// ============================================================================
//  Module   : bgm_player
//  Purpose  : Background-music sequencer plus square-wave tone generator.
//             Steps a beat index through an external tone table at a
//             selectable tempo (play / pause / stop, loop or one-shot) and
//             turns each table frequency into a clock-divided square wave.
//  Ports    : clk        system clock, rising edge
//             rst_n      asynchronous active-low reset
//             play       level: 1 = run, 0 = pause
//             stop       rewind to index 0 and mute, overrides play
//             loop_en    1 = wrap after LEN-1, 0 = one-shot
//             tempo_sel  tick period = TICK_DIV >> tempo_sel (3 acts as 2)
//             tbl_bus    tone-table bus (beat_num out, tone in)
//             audio      square-wave output
//             playing    high while the sequencer is in PLAY
//             done       one-cycle pulse on one-shot completion
//  Revision : 1.0  initial release
// ============================================================================
module bgm_player #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned LEN       = 416,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned SILENT_HZ = 20000
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              play,
    input  wire              stop,
    input  wire              loop_en,
    input  wire  [1:0]       tempo_sel,
    bgm_player_if.master     tbl_bus,
    output logic             audio,
    output logic             playing,
    output logic             done
);

    localparam logic [ADDR_W-1:0] c_last_beat = ADDR_W'(LEN - 1);
    localparam logic [31:0]       c_clk_freq  = 32'(CLK_FREQ);
    localparam logic [31:0]       c_silent_hz = 32'(SILENT_HZ);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        SEQ_STOP  = 2'd0,
        SEQ_PLAY  = 2'd1,
        SEQ_PAUSE = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_t;

    seq_t              r_seq, w_seq_nxt;
    logic [ADDR_W-1:0] r_beat, w_beat_nxt;
    logic [31:0]       r_tick, w_tick_nxt;
    logic              r_done, w_done_nxt;

    logic [1:0]  w_shift;
    logic [31:0] w_limit;
    logic        w_tick_term;

    assign w_shift = (tempo_sel == 2'd3) ? 2'd2 : tempo_sel;
    assign w_limit = 32'(TICK_DIV) >> w_shift;
    // '>=' rather than '==' so a tempo speed-up that leaves the counter past
    // the new limit still wraps on the following cycle.
    assign w_tick_term = (w_limit <= 32'd1) || (r_tick >= (w_limit - 32'd1));

    always_comb begin
        w_seq_nxt  = r_seq;
        w_beat_nxt = r_beat;
        w_tick_nxt = r_tick;
        w_done_nxt = 1'b0;
        if (stop) begin
            w_seq_nxt  = SEQ_STOP;
            w_beat_nxt = '0;
            w_tick_nxt = '0;
        end else begin
            case (r_seq)
                SEQ_STOP, SEQ_PAUSE: begin
                    if (play) w_seq_nxt = SEQ_PLAY;
                end
                SEQ_PLAY: begin
                    if (!play) begin
                        w_seq_nxt = SEQ_PAUSE;
                    end else if (w_tick_term) begin
                        w_tick_nxt = '0;
                        if (r_beat == c_last_beat) begin
                            if (loop_en) begin
                                w_beat_nxt = '0;
                            end else begin
                                w_seq_nxt  = SEQ_DONE;
                                w_done_nxt = 1'b1;
                            end
                        end else begin
                            w_beat_nxt = r_beat + ADDR_W'(1);
                        end
                    end else begin
                        w_tick_nxt = r_tick + 32'd1;
                    end
                end
                default: ; // SEQ_DONE: only stop leaves
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq  <= SEQ_STOP;
            r_beat <= '0;
            r_tick <= '0;
            r_done <= 1'b0;
        end else begin
            r_seq  <= w_seq_nxt;
            r_beat <= w_beat_nxt;
            r_tick <= w_tick_nxt;
            r_done <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Tone generator
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        TN_SILENT = 2'd0,
        TN_CALC   = 2'd1,
        TN_SQUARE = 2'd2
    } tone_t;

    tone_t       r_tst, w_tst_nxt;
    logic [31:0] r_tone_cur, w_tone_cur_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [32:0] r_rem, w_rem_nxt;
    logic [31:0] r_quo, w_quo_nxt;
    logic [32:0] r_dvs, w_dvs_nxt;
    logic [31:0] r_half, w_half_nxt;
    logic [31:0] r_per, w_per_nxt;
    logic        r_aud, w_aud_nxt;

    logic        w_run;
    logic        w_tone_silent;
    logic [33:0] w_shl;
    logic        w_ge;
    logic [32:0] w_rem_it;
    logic [31:0] w_quo_it;

    assign w_run         = (r_seq == SEQ_PLAY);
    assign w_tone_silent = (tbl_bus.tone == 32'd0) || (tbl_bus.tone >= c_silent_hz);

    // One restoring-division step: shift the next dividend bit (kept in the
    // top of r_quo) into the partial remainder and subtract if it fits.
    assign w_shl    = {r_rem, r_quo[31]};
    assign w_ge     = (w_shl >= {1'b0, r_dvs});
    assign w_rem_it = w_ge ? 33'(w_shl - {1'b0, r_dvs}) : w_shl[32:0];
    assign w_quo_it = {r_quo[30:0], w_ge};

    always_comb begin
        w_tst_nxt      = r_tst;
        w_tone_cur_nxt = r_tone_cur;
        w_cnt_nxt      = r_cnt;
        w_rem_nxt      = r_rem;
        w_quo_nxt      = r_quo;
        w_dvs_nxt      = r_dvs;
        w_half_nxt     = r_half;
        w_per_nxt      = r_per;
        w_aud_nxt      = r_aud;
        if (!w_run) begin
            // Clearing tone_cur forces a fresh divide when playback resumes.
            w_tst_nxt      = TN_SILENT;
            w_tone_cur_nxt = '0;
            w_cnt_nxt      = '0;
            w_per_nxt      = '0;
            w_aud_nxt      = 1'b0;
        end else begin
            case (r_tst)
                TN_CALC: begin
                    w_aud_nxt = 1'b0;
                    if (r_cnt == 6'd0) begin
                        w_rem_nxt = '0;
                        w_quo_nxt = c_clk_freq;
                        w_dvs_nxt = {r_tone_cur, 1'b0};
                        w_cnt_nxt = 6'd1;
                    end else begin
                        w_rem_nxt = w_rem_it;
                        w_quo_nxt = w_quo_it;
                        w_cnt_nxt = r_cnt + 6'd1;
                        if (r_cnt == 6'd32) begin
                            w_half_nxt = w_quo_it;
                            w_per_nxt  = '0;
                            // half == 0 means the tone exceeds CLK_FREQ/2.
                            w_tst_nxt  = (w_quo_it == 32'd0) ? TN_SILENT : TN_SQUARE;
                        end
                    end
                end
                default: begin
                    if (tbl_bus.tone != r_tone_cur) begin
                        w_tone_cur_nxt = tbl_bus.tone;
                        w_cnt_nxt      = '0;
                        w_per_nxt      = '0;
                        w_aud_nxt      = 1'b0;
                        w_tst_nxt      = w_tone_silent ? TN_SILENT : TN_CALC;
                    end else if (r_tst == TN_SQUARE) begin
                        if (r_per == (r_half - 32'd1)) begin
                            w_per_nxt = '0;
                            w_aud_nxt = ~r_aud;
                        end else begin
                            w_per_nxt = r_per + 32'd1;
                        end
                    end else begin
                        w_aud_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tst      <= TN_SILENT;
            r_tone_cur <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_half     <= '0;
            r_per      <= '0;
            r_aud      <= 1'b0;
        end else begin
            r_tst      <= w_tst_nxt;
            r_tone_cur <= w_tone_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rem      <= w_rem_nxt;
            r_quo      <= w_quo_nxt;
            r_dvs      <= w_dvs_nxt;
            r_half     <= w_half_nxt;
            r_per      <= w_per_nxt;
            r_aud      <= w_aud_nxt;
        end
    end

    // Gating with the sequencer state mutes audio in the same cycle playback
    // leaves PLAY (pause, stop, one-shot completion).
    assign audio            = r_aud & w_run;
    assign playing          = w_run;
    assign done             = r_done;
    assign tbl_bus.beat_num = r_beat;

endmodule
`default_nettype wire

// File: tb/tb_bgm_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bgm_player
//  Purpose  : Self-checking bench for bgm_player. Expected beat changes,
//             audio edges and done pulses are queued with their cycle numbers
//             as stimulus is applied; a negedge monitor pops and compares
//             them as the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bgm_player;

    localparam int CLK_HZ = 1000;
    localparam int TDIV   = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play;
    logic       stop;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic       audio;
    logic       playing;
    logic       done;

    int unsigned tbl [4];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;
    logic [1:0]  prev_beat = 2'd0;
    logic        prev_aud = 1'b0;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_beat [$];
    ev_t q_aud  [$];
    ev_t q_done [$];
    ev_t m_ev;

    bgm_player_if #(.ADDR_W(2)) tbus ();
    assign tbus.tone = tbl[tbus.beat_num];

    bgm_player #(
        .CLK_FREQ  (CLK_HZ),
        .TICK_DIV  (TDIV),
        .LEN       (4),
        .ADDR_W    (2),
        .SILENT_HZ (20000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .stop      (stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .tbl_bus   (tbus),
        .audio     (audio),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_beat(input int c, input int v);
        q_beat.push_back('{cyc: c, val: v});
    endtask

    // A tone latched at 'latch' stays low through the divide, first toggles
    // at latch+33+half, then every half cycles, and is forced low at end_c.
    task automatic push_tone(input int latch, input int hz, input int end_c);
        int half = CLK_HZ / (2 * hz);
        int t    = latch + 33 + half;
        int lvl  = 0;
        while (t < end_c) begin
            lvl ^= 1;
            q_aud.push_back('{cyc: t, val: lvl});
            t += half;
        end
        if (lvl != 0) q_aud.push_back('{cyc: end_c, val: 0});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tbus.beat_num !== prev_beat) begin
                if (q_beat.size() != 0) m_ev = q_beat.pop_front();
                else m_ev = '{cyc: -1, val: -1};
                chk("beat_cycle", cyc, m_ev.cyc);
                chk("beat_value", tbus.beat_num, m_ev.val);
            end
            if (audio !== prev_aud) begin
                if (q_aud.size() != 0) m_ev = q_aud.pop_front();
                else m_ev = '{cyc: -1, val: -1};
                chk("audio_edge_cycle", cyc, m_ev.cyc);
                chk("audio_edge_level", audio, m_ev.val);
            end
            if (done !== 1'b0) begin
                if (q_done.size() != 0) m_ev = q_done.pop_front();
                else m_ev = '{cyc: -1, val: -1};
                chk("done_cycle", cyc, m_ev.cyc);
                chk("done_level", done, m_ev.val);
            end
        end
        prev_beat = tbus.beat_num;
        prev_aud  = audio;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        int p, s, p2, q, r, t, p3, p4;
        rst_n = 1'b0; play = 1'b0; stop = 1'b0; loop_en = 1'b0; tempo_sel = 2'd0;
        tbl[0] = 25; tbl[1] = 25; tbl[2] = 20000; tbl[3] = 50;
        wait_cyc(3);
        chk("rst_beat",    tbus.beat_num, 0);
        chk("rst_audio",   audio, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done",    done, 0);
        rst_n = 1'b1;
        wait_cyc(5);
        mon_en = 1'b1;

        // One-shot at base tempo: beats every 128 cycles, done after index 3.
        p = cyc + 1;
        push_beat(p + 128, 1); push_beat(p + 256, 2); push_beat(p + 384, 3);
        push_tone(p + 1, 25, p + 257);
        push_tone(p + 385, 50, p + 512);
        q_done.push_back('{cyc: p + 512, val: 1});
        play = 1'b1;
        wait_cyc(p);
        chk("a_playing_on", playing, 1);
        wait_cyc(p + 512);
        chk("a_playing_off", playing, 0);
        wait_cyc(p + 540);
        chk("a_beat_held", tbus.beat_num, 3);
        chk("a_audio_done", audio, 0);

        // stop with play held wins; then loop at tempo_sel=1 (64 cycles/beat).
        s = cyc + 1;
        push_beat(s, 0);
        stop = 1'b1; loop_en = 1'b1; tempo_sel = 2'd1;
        wait_cyc(s);
        chk("b_stop_playing", playing, 0);
        stop = 1'b0;
        p2 = s + 1;
        push_beat(p2 + 64, 1); push_beat(p2 + 128, 2); push_beat(p2 + 192, 3);
        push_beat(p2 + 256, 0); push_beat(p2 + 320, 1);
        q = p2 + 360;
        push_tone(p2 + 1, 25, p2 + 129);
        push_tone(p2 + 193, 50, p2 + 257);
        push_tone(p2 + 257, 25, q);

        // Pause 10 cycles mid-beat: 39 ticks done, 25 remain after resume.
        wait_cyc(q - 1);
        play = 1'b0;
        wait_cyc(q);
        chk("c_pause_playing", playing, 0);
        r = q + 10;
        push_beat(r + 25, 2);
        push_tone(r + 1, 25, r + 26);
        wait_cyc(q + 5);
        chk("c_pause_beat", tbus.beat_num, 1);
        chk("c_pause_audio", audio, 0);
        wait_cyc(r - 1);
        play = 1'b1;

        // stop during index 2, held with play=1 for three cycles.
        t = r + 50;
        wait_cyc(t - 1);
        stop = 1'b1;
        push_beat(t, 0);
        wait_cyc(t);
        chk("d_stop_playing", playing, 0);
        chk("d_stop_audio", audio, 0);
        wait_cyc(t + 2);
        chk("d_stop_wins", playing, 0);
        stop = 1'b0;
        p3 = t + 3;
        wait_cyc(p3);
        chk("d_restart_playing", playing, 1);

        // Asynchronous reset in the middle of the divide.
        wait_cyc(p3 + 20);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_playing", playing, 0);
        chk("e_rst_beat", tbus.beat_num, 0);
        chk("e_rst_audio", audio, 0);
        chk("e_rst_done", done, 0);
        play = 1'b0;
        tbl[0] = 600; tbl[1] = 0; tbl[2] = 600; tbl[3] = 0;
        loop_en = 1'b0; tempo_sel = 2'd3;

        // Silent tones (0 and above CLK_FREQ/2); tempo_sel=3 runs as 2.
        wait_cyc(p3 + 22);
        rst_n = 1'b1;
        play  = 1'b1;
        p4 = cyc + 1;
        push_beat(p4 + 32, 1); push_beat(p4 + 64, 2); push_beat(p4 + 96, 3);
        q_done.push_back('{cyc: p4 + 128, val: 1});
        wait_cyc(p4 + 140);
        chk("f_playing_off", playing, 0);
        chk("f_beat_held", tbus.beat_num, 3);

        chk("left_beat_events",  q_beat.size(), 0);
        chk("left_audio_events", q_aud.size(), 0);
        chk("left_done_events",  q_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
